// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit processor: bus widths, the control-word
// bit map used by both the decode ROM and the datapath, and the phase encoding.
package cpu_pkg;

    localparam int PC_W = 12;
    localparam int CW_W = 13;

    // Control word bit positions
    localparam int CW_INCPC     = 12;
    localparam int CW_LOADPC    = 11;
    localparam int CW_LOADA     = 10;
    localparam int CW_LOADFLAGS = 9;

    typedef enum logic {
        PH_FETCH = 1'b0,
        PH_EXEC  = 1'b1
    } phase_e;

    // Decode ROM address layout: {instr, c, z, phase}
    function automatic logic [6:0] make_dec_addr(input logic [3:0] instr,
                                                 input logic       c,
                                                 input logic       z,
                                                 input phase_e     ph);
        return {instr, c, z, logic'(ph)};
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, program memory, decode ROM and ALU.
// The master side is the sequencer; the slave side is its environment.
interface fetch_sequencer_if #(
    parameter int CNT_W = 16
);
    import cpu_pkg::*;

    logic [PC_W-1:0]  prog_addr;
    logic [7:0]       prog_byte;
    logic [CW_W-1:0]  ctrl_word;
    logic [PC_W-1:0]  jump_addr;
    logic             alu_c;
    logic             alu_z;
    logic [6:0]       dec_addr;
    logic [3:0]       oprnd;
    logic             phase;
    logic             c_flag;
    logic             z_flag;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output prog_addr, dec_addr, oprnd, phase, c_flag, z_flag, instr_count,
        input  prog_byte, ctrl_word, jump_addr, alu_c, alu_z
    );

    modport slave (
        input  prog_addr, dec_addr, oprnd, phase, c_flag, z_flag, instr_count,
        output prog_byte, ctrl_word, jump_addr, alu_c, alu_z
    );

endinterface

// File: rtl/fetch_sequencer_pc_counter.sv
// Program counter: synchronous reset, clock enable, load takes priority over
// increment, increment wraps modulo 2^W.
module pc_counter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] pc
);

    logic [W-1:0] pc_reg;
    logic [W-1:0] pc_next;

    // Next PC: jump beats increment, otherwise hold
    always_comb begin
        pc_next = pc_reg;
        if (load) begin
            pc_next = load_value;
        end else if (inc) begin
            pc_next = pc_reg + W'(1);
        end
    end

    // PC register, frozen while enable is low
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg <= '0;
        end else if (enable) begin
            pc_reg <= pc_next;
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns PC, fetch/execute phase, fetch register, C/Z flags
// and the retired-instruction counter; forms the decode ROM address from
// registered state only so the ROM feedback loop stays acyclic.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    fetch_sequencer_if.master  bus
);

    phase_e           phase_reg;
    phase_e           phase_next;
    logic [7:0]       fetch_reg;
    logic [7:0]       fetch_next;
    logic             c_flag_reg;
    logic             c_flag_next;
    logic             z_flag_reg;
    logic             z_flag_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [PC_W-1:0]  pc;

    logic inc_pc;
    logic load_pc;
    logic load_flags;

    assign inc_pc     = bus.ctrl_word[CW_INCPC];
    assign load_pc    = bus.ctrl_word[CW_LOADPC];
    assign load_flags = bus.ctrl_word[CW_LOADFLAGS];

    // Remaining control bits belong to the datapath
    logic unused_ctrl;
    assign unused_ctrl = ^{bus.ctrl_word[CW_LOADA], bus.ctrl_word[8:0]};

    pc_counter #(
        .W(PC_W)
    ) u_pc (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .load      (load_pc),
        .inc       (inc_pc),
        .load_value(bus.jump_addr),
        .pc        (pc)
    );

    // Phase state register
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_reg <= PH_FETCH;
        end else if (enable) begin
            phase_reg <= phase_next;
        end
    end

    // Phase next-state: alternate fetch and execute
    always_comb begin
        phase_next = phase_reg;
        case (phase_reg)
            PH_FETCH: phase_next = PH_EXEC;
            PH_EXEC:  phase_next = PH_FETCH;
            default:  phase_next = PH_FETCH;
        endcase
    end

    // Datapath next values: fetch capture, flag load, saturating count
    always_comb begin
        fetch_next  = fetch_reg;
        c_flag_next = c_flag_reg;
        z_flag_next = z_flag_reg;
        count_next  = count_reg;
        if (phase_reg == PH_FETCH) begin
            fetch_next = bus.prog_byte;
        end
        if (load_flags) begin
            c_flag_next = bus.alu_c;
            z_flag_next = bus.alu_z;
        end
        if (phase_reg == PH_EXEC && count_reg != {CNT_W{1'b1}}) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    // Datapath registers, frozen while enable is low
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_reg  <= 8'h00;
            c_flag_reg <= 1'b0;
            z_flag_reg <= 1'b0;
            count_reg  <= '0;
        end else if (enable) begin
            fetch_reg  <= fetch_next;
            c_flag_reg <= c_flag_next;
            z_flag_reg <= z_flag_next;
            count_reg  <= count_next;
        end
    end

    assign bus.prog_addr   = pc;
    assign bus.dec_addr    = make_dec_addr(fetch_reg[7:4], c_flag_reg, z_flag_reg, phase_reg);
    assign bus.oprnd       = fetch_reg[3:0];
    assign bus.phase       = phase_reg;
    assign bus.c_flag      = c_flag_reg;
    assign bus.z_flag      = z_flag_reg;
    assign bus.instr_count = count_reg;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream stage of the microcode decode ROM in the 4-bit processor.
- Owns the program counter, the fetch/execute phase bit, the fetch register (instruction and operand nibbles) and the C/Z flags register.
- Builds the 7-bit decode address {instr[3:0], c_flag, z_flag, phase} each cycle.
- Consumes the PC and flags fields of the 13-bit control word that the decode ROM returns.

Parameters:
PC_W, 12, program counter / program memory address width
CW_W, 13, control word width from decode ROM
CNT_W, 16, retired-instruction counter width

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state on the next clk edge
enable  input  1  1 = advance; 0 = freeze all registers (run/halt)
prog_addr  output  PC_W  program memory address, equals pc
prog_byte  input  8  program memory data for prog_addr, combinational (asynchronous ROM)
ctrl_word  input  CW_W  control word from decode ROM for current dec_addr
jump_addr  input  PC_W  jump target, taken when loadPC asserted
alu_c  input  1  ALU carry, captured on loadFlags
alu_z  input  1  ALU zero, captured on loadFlags
dec_addr  output  7  decode ROM address {instr, c_flag, z_flag, phase}
oprnd  output  4  operand nibble, fetch_reg[3:0]
phase  output  1  0 = fetch, 1 = execute
c_flag  output  1  registered carry
z_flag  output  1  registered zero
instr_count  output  CNT_W  retired instructions, saturating

Behaviour:
- Reset values: pc=0, phase=0, fetch_reg=8'h00, c_flag=0, z_flag=0, instr_count=0. Reset overrides enable.
- Reset values on outputs: prog_addr=0, dec_addr=7'b0000000, oprnd=0.
- Control bit positions used: ctrl_word[12]=incPC, [11]=loadPC, [9]=loadFlags. All other bits are ignored here.
- All updates below occur only on clk edges with reset=0 and enable=1. With enable=0, every register holds its value and outputs are stable.
- Phase: toggles every enabled cycle (0→1→0…).
- Fetch register:
  - Loads prog_byte on an enabled edge while phase=0.
  - Holds while phase=1.
  - instr = fetch_reg[7:4], oprnd = fetch_reg[3:0].
- PC update, priority order:
  - loadPC=1 → pc <= jump_addr.
  - else incPC=1 → pc <= pc+1, modulo 2^PC_W (4095 wraps to 0).
  - else hold.
  - loadPC and incPC both 1 → loadPC wins.
- Flags: loadFlags=1 → c_flag<=alu_c, z_flag<=alu_z (same edge); otherwise hold. Flags are never loaded by phase alone.
- Counter:
  - instr_count increments on each enabled edge with phase=1 (execute completes).
  - Saturates at 2^CNT_W-1.
- dec_addr is combinational from registers only (no path from ctrl_word), so the ROM→sequencer loop has no combinational cycle.
- Latency:
  - A byte at address N is presented on prog_addr in fetch phase and appears in dec_addr[6:3] one cycle later with phase=1.
  - One instruction takes 2 enabled cycles.
- Enable deasserted mid-instruction (phase=1): state frozen, and execution resumes in execute phase when re-enabled.
- Reset mid-instruction: returns to fetch phase at pc=0 on the next edge, discarding fetch_reg.

Decomposition:
- Shared package cpu_pkg:
  - CW_W, PC_W.
  - Control-bit index constants CW_INCPC=12, CW_LOADPC=11, CW_LOADA=10, CW_LOADFLAGS=9, so the decode ROM and datapath share one bit map.
  - Phase encodings PH_FETCH=0, PH_EXEC=1.
- One natural sub-module: pc_counter (PC_W-bit register with synchronous reset, enable, load-over-increment priority). Phase, fetch register, flags and counter stay inline.

Test Plan:
- Reset with enable=1, then release; prog_byte=8'h2A at addr 0, ctrl incPC=1 in phase 0 only → after edge 1: phase=1, dec_addr=7'b0010_00_1, oprnd=4'hA, pc=1; after edge 2: phase=0, instr_count=1.
- Jump priority: ctrl_word with both incPC and loadPC=1, jump_addr=12'h3F0 → pc=12'h3F0 next edge (not pc+1).
- Wrap: force pc=12'hFFF, incPC=1 → pc=12'h000, no other state disturbed.
- Flags: loadFlags=1, alu_c=1, alu_z=0 → c_flag=1, z_flag=0 and dec_addr[2:1]=2'b10. Next cycle loadFlags=0, alu_c=0 → flags hold.
- Freeze: enable=0 for 5 cycles during phase=1 with incPC=1 → pc, phase, fetch_reg, instr_count unchanged. Re-enable → pc advances exactly once.
- Reset mid-execute: pc=12'h010, phase=1, reset pulse one cycle → pc=0, phase=0, flags=0, instr_count=0; enable ignored during reset.
